counter_updown_mod: RTL

//   Parametrised up/down modulo counter with enable, synchronous clear, parallel load,

---
 rtl/counter_updown_mod_pkg.sv | 8 +
 rtl/counter_next_value.sv | 38 +++
 rtl/counter_updown_mod.sv | 72 +++++++
 3 files changed

// File: rtl/counter_updown_mod_pkg.sv
// rtl/counter_updown_mod_pkg.sv - shared encodings for the modulo counter family
package counter_updown_mod_pkg;

    // Values for the SATURATE parameter of counters in this family
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/counter_next_value.sv
// rtl/counter_next_value.sv - next count and wrap flag for one counting step
module counter_next_value #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             saturate,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    // Step by one toward the requested end; at the end either wrap around or hold
    always_comb begin
        next = q;
        wrap = 1'b0;
        if (up) begin
            if (q == max) begin
                if (!saturate) begin
                    next = '0;
                    wrap = 1'b1;
                end
            end else begin
                next = q + WIDTH'(1);
            end
        end else begin
            if (q == '0) begin
                if (!saturate) begin
                    next = max;
                    wrap = 1'b1;
                end
            end else begin
                next = q - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - up/down modulo counter with clear, load, TC and wrap pulse
module counter_updown_mod
    import counter_updown_mod_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             Clk,
    input  logic             RSTB,
    input  logic             EN,
    input  logic             UP,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_cnt;
    logic             step_wrap;
    logic [WIDTH-1:0] load_val;
    logic             saturate_mode;

    assign saturate_mode = (SATURATE == MODE_SAT);

    counter_next_value #(
        .WIDTH(WIDTH)
    ) u_next (
        .q        (Q),
        .up       (UP),
        .saturate (saturate_mode),
        .max      (MAX),
        .next     (next_cnt),
        .wrap     (step_wrap)
    );

    // A full-range counter accepts any D; otherwise clamp loads to MAX so Q stays in range
    generate
        if (MODULUS == 2**WIDTH) begin : g_full_range
            assign load_val = D;
        end else begin : g_clamp
            assign load_val = (D > MAX) ? MAX : D;
        end
    endgenerate

    // Terminal count: the next enabled step in the current direction hits the end of the range
    assign TC = EN & ~CLR & ~LOAD & (UP ? (Q == MAX) : (Q == '0));

    // Count and wrap-pulse registers with CLR > LOAD > EN > hold priority
    always_ff @(posedge Clk or negedge RSTB) begin
        if (!RSTB) begin
            Q    <= '0;
            WRAP <= 1'b0;
        end else if (CLR) begin
            Q    <= '0;
            WRAP <= 1'b0;
        end else if (LOAD) begin
            Q    <= load_val;
            WRAP <= 1'b0;
        end else if (EN) begin
            Q    <= next_cnt;
            WRAP <= step_wrap;
        end else begin
            WRAP <= 1'b0;
        end
    end

endmodule
